procyon_sync_fifo: RTL and testbench

Synchronous single-clock FIFO with valid/ready handshakes on both sides. It owns the read/write pointer logic and occupancy tracking, and drives the dual-port RAM storage directly as that RAM's only read and write client. It is used between pipeline stages, for example as a fetch queue or a load/store buffer, wherever decoupling storage with back-pressure is needed.

---
 rtl/procyon_ram_dp.sv | 30 +++
 rtl/procyon_sync_fifo.sv | 87 ++++++++
 tb/tb_procyon_sync_fifo.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/procyon_ram_dp.sv
// Dual-port RAM: one synchronous write port, one asynchronous read port.
// Ports: clk, n_rst (active-low; blocks writes and zeroes read data),
// wr_en/wr_addr/wr_data write port, rd_en/rd_addr/rd_data read port.
module procyon_ram_dp #(
    parameter int OPTN_DATA_WIDTH = 8,
    parameter int OPTN_RAM_DEPTH  = 8,
    parameter int RAM_IDX_WIDTH   = $clog2(OPTN_RAM_DEPTH)
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       wr_en,
    input  logic [RAM_IDX_WIDTH-1:0]   wr_addr,
    input  logic [OPTN_DATA_WIDTH-1:0] wr_data,
    input  logic                       rd_en,
    input  logic [RAM_IDX_WIDTH-1:0]   rd_addr,
    output logic [OPTN_DATA_WIDTH-1:0] rd_data
);

    logic [OPTN_DATA_WIDTH-1:0] mem [0:OPTN_RAM_DEPTH-1];

    // Contents are deliberately not reset; only the write is gated.
    always_ff @(posedge clk) begin
        if (n_rst && wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = (n_rst && rd_en) ? mem[rd_addr] : '0;

endmodule

// File: rtl/procyon_sync_fifo.sv
// Single-clock FIFO with valid/ready on both sides, pointer-based occupancy.
// Ports: clk, rst (async, active-high), i_flush, enqueue handshake
// (i_enq_valid/o_enq_ready/i_enq_data), dequeue handshake
// (o_deq_valid/i_deq_ready/o_deq_data), status count/full/empty/almost_full.
module procyon_sync_fifo #(
    parameter int OPTN_DATA_WIDTH   = 8,
    parameter int OPTN_FIFO_DEPTH   = 8,
    parameter int OPTN_AF_THRESHOLD = OPTN_FIFO_DEPTH - 1,
    parameter int FIFO_IDX_WIDTH    = $clog2(OPTN_FIFO_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_enq_valid,
    output logic                       o_enq_ready,
    input  logic [OPTN_DATA_WIDTH-1:0] i_enq_data,
    output logic                       o_deq_valid,
    input  logic                       i_deq_ready,
    output logic [OPTN_DATA_WIDTH-1:0] o_deq_data,
    output logic [FIFO_IDX_WIDTH:0]    o_fifo_count,
    output logic                       o_fifo_full,
    output logic                       o_fifo_empty,
    output logic                       o_fifo_almost_full
);

    localparam int PTR_WIDTH = FIFO_IDX_WIDTH + 1;

    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [PTR_WIDTH-1:0] count;
    logic                 full;
    logic                 empty;
    logic                 enq_fire;
    logic                 deq_fire;
    logic                 ram_we;

    // The MSB is a wrap bit: equal low bits with differing wrap bits is full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_IDX_WIDTH-1:0] == rd_ptr[FIFO_IDX_WIDTH-1:0]) &&
                   (wr_ptr[FIFO_IDX_WIDTH] != rd_ptr[FIFO_IDX_WIDTH]);
    assign count = wr_ptr - rd_ptr;

    assign enq_fire = i_enq_valid & ~full;
    assign deq_fire = ~empty & i_deq_ready;

    // A flush in the same cycle drops the write.
    assign ram_we = enq_fire & ~i_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
        end
    end

    procyon_ram_dp #(
        .OPTN_DATA_WIDTH(OPTN_DATA_WIDTH),
        .OPTN_RAM_DEPTH (OPTN_FIFO_DEPTH)
    ) procyon_ram_dp_inst (
        .clk    (clk),
        .n_rst  (~rst),
        .wr_en  (ram_we),
        .wr_addr(wr_ptr[FIFO_IDX_WIDTH-1:0]),
        .wr_data(i_enq_data),
        .rd_en  (~empty),
        .rd_addr(rd_ptr[FIFO_IDX_WIDTH-1:0]),
        .rd_data(o_deq_data)
    );

    assign o_enq_ready        = ~full;
    assign o_deq_valid        = ~empty;
    assign o_fifo_count       = count;
    assign o_fifo_full        = full;
    assign o_fifo_empty       = empty;
    assign o_fifo_almost_full = (count >= PTR_WIDTH'(OPTN_AF_THRESHOLD));

endmodule

// File: tb/tb_procyon_sync_fifo.sv
// Testbench for procyon_sync_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-based occupancy/data model.
module tb_procyon_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = DEPTH - 1;
    localparam int IW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          enq_valid = 1'b0;
    logic          enq_ready;
    logic [DW-1:0] enq_data = '0;
    logic          deq_valid;
    logic          deq_ready = 1'b0;
    logic [DW-1:0] deq_data;
    logic [IW:0]   fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_af;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] q [$];

    procyon_sync_fifo #(
        .OPTN_DATA_WIDTH  (DW),
        .OPTN_FIFO_DEPTH  (DEPTH),
        .OPTN_AF_THRESHOLD(AF)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_flush           (flush),
        .i_enq_valid       (enq_valid),
        .o_enq_ready       (enq_ready),
        .i_enq_data        (enq_data),
        .o_deq_valid       (deq_valid),
        .i_deq_ready       (deq_ready),
        .o_deq_data        (deq_data),
        .o_fifo_count      (fifo_count),
        .o_fifo_full       (fifo_full),
        .o_fifo_empty      (fifo_empty),
        .o_fifo_almost_full(fifo_af)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs follow from the occupancy and head of the model queue.
    task automatic check_outputs();
        int sz;
        logic [DW-1:0] head;
        sz = q.size();
        head = (sz > 0) ? q[0] : '0;
        chk("count", 32'(fifo_count), 32'(sz));
        chk("empty", 32'(fifo_empty), 32'(sz == 0));
        chk("full", 32'(fifo_full), 32'(sz == DEPTH));
        chk("almost_full", 32'(fifo_af), 32'(sz >= AF));
        chk("enq_ready", 32'(enq_ready), 32'(sz != DEPTH));
        chk("deq_valid", 32'(deq_valid), 32'(sz != 0));
        chk("deq_data", 32'(deq_data), 32'(head));
    endtask

    // Called just after a falling edge: drive, check, take one rising edge.
    task automatic step(input logic ev, input logic [DW-1:0] ed,
                        input logic dr, input logic fl);
        logic efire;
        logic dfire;
        enq_valid = ev;
        enq_data  = ed;
        deq_ready = dr;
        flush     = fl;
        #1;
        check_outputs();
        efire = ev && (q.size() < DEPTH);
        dfire = dr && (q.size() > 0);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (dfire) void'(q.pop_front());
            if (efire) q.push_back(ed);
        end
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_outputs();

        // Fill with 0x11..0x88, then one dropped enqueue while full.
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, DW'(8'h11 * i), 1'b0, 1'b0);
        end
        step(1'b1, 8'h99, 1'b0, 1'b0);
        chk("full_after_fill", 32'(fifo_full), 32'd1);

        // Full with dequeue: the enqueue is still refused.
        step(1'b1, 8'h99, 1'b1, 1'b0);
        chk("no_enq_when_full", 32'(fifo_count), 32'(DEPTH - 1));
        for (int i = 0; i < DEPTH - 1; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
        end
        chk("drained_empty", 32'(fifo_empty), 32'd1);

        // Steady state at count 3 with simultaneous traffic.
        for (int i = 0; i < 3; i++) step(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, DW'(8'h20 + i), 1'b1, 1'b0);
        end
        chk("steady_count", 32'(fifo_count), 32'd3);
        step(1'b0, '0, 1'b0, 1'b1);

        // Flush at count 5 drops a concurrent enqueue.
        for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b1);
        chk("flush_count", 32'(fifo_count), 32'd0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle at count 4.
        for (int i = 0; i < 4; i++) step(1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        chk("async_rst_count", 32'(fifo_count), 32'd0);
        chk("async_rst_empty", 32'(fifo_empty), 32'd1);
        chk("async_rst_data", 32'(deq_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("post_rst_data", 32'(deq_data), 32'h5A);
        step(1'b0, '0, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 60), DW'($urandom),
                 1'($urandom_range(0, 99) < 50),
                 1'($urandom_range(0, 99) < 3));
        end
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
